// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero and signed-overflow flags and a valid/ready handshake.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module addsub #(
  parameter int w = 9
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [w-1:0] sum,
  output logic         cout
);
  logic [w:0] full;

  // In subtract mode cin acts as a borrow-in, so sub=1/cin=0 yields a - b and cout=1 means no borrow.
  assign full = {1'b0, a} + {1'b0, b ^ {w{sub}}} + {{w{1'b0}}, cin ^ sub};
  assign sum  = full[w-1:0];
  assign cout = full[w];
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for a request
// CALC  | one restoring iteration per clock, sign fix-up on the last one
// DONE  | result held; out_valid rises one cycle after entry, exits on out_ready
module seq_divider #(
  parameter int n = `DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  input  logic         signed_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_zero,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int cw = (n > 2) ? $clog2(n) : 1;

  state_t        state;
  logic [n-1:0]  dvd_sh;
  logic [n-1:0]  dsr_mag;
  logic [n-1:0]  quo;
  logic [n-1:0]  rem;
  logic [cw-1:0] cnt;
  logic          q_neg;
  logic          r_neg;
  logic          ovf_pend;

  logic          dvd_neg;
  logic          dsr_neg;
  logic [n-1:0]  dvd_abs;
  logic [n-1:0]  dsr_abs;
  logic          is_ovf;
  logic [n:0]    shifted;
  logic [n:0]    diff;
  logic          cout;
  logic          take;
  logic [n-1:0]  quo_next;
  logic [n-1:0]  rem_next;

  assign dvd_neg = signed_op & dividend[n-1];
  assign dsr_neg = signed_op & divisor[n-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dsr_abs = dsr_neg ? -divisor : divisor;
  assign is_ovf  = signed_op && (dividend == {1'b1, {(n-1){1'b0}}}) && (divisor == {n{1'b1}});

  assign shifted = {rem, dvd_sh[n-1]};

  addsub #(.w(n+1)) u_addsub (
    .a    (shifted),
    .b    ({1'b0, dsr_mag}),
    .sub  (1'b1),
    .cin  (1'b0),
    .sum  (diff),
    .cout (cout)
  );

  // diff[n] is always 0 when there is no borrow; folding it in keeps every sum bit live.
  assign take     = cout & ~diff[n];
  assign quo_next = {quo[n-2:0], take};
  assign rem_next = take ? diff[n-1:0] : shifted[n-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      dvd_sh    <= '0;
      dsr_mag   <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient  <= {n{1'b1}};
              remainder <= dividend;
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
              state     <= DONE;
            end else begin
              dvd_sh   <= dvd_abs;
              dsr_mag  <= dsr_abs;
              quo      <= '0;
              rem      <= '0;
              cnt      <= cw'(n - 1);
              q_neg    <= dvd_neg ^ dsr_neg;
              r_neg    <= dvd_neg;
              ovf_pend <= is_ovf;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          quo    <= quo_next;
          rem    <= rem_next;
          dvd_sh <= {dvd_sh[n-2:0], 1'b0};
          if (cnt == '0) begin
            quotient  <= q_neg ? -quo_next : quo_next;
            remainder <= r_neg ? -rem_next : rem_next;
            div_zero  <= 1'b0;
            ovf       <= ovf_pend;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: n, default `DEFAULT_WIDTH (from defines.v), operand/result width in bits; legal n >= 2.
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports: dividend, divisor  input  n  operands.
REQ-007 SHALL have port: signed_op  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports: quotient, remainder  output  n  results.
REQ-011 SHALL have port: div_zero  output  1  divisor was zero.
REQ-012 SHALL have port: ovf  output  1  signed overflow (most-negative / -1).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted on an edge where in_valid & in_ready.
REQ-015 SHALL, on accept, latch operands and signed_op; signed mode stores operand magnitudes and result sign flags (quotient negative = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend)).
REQ-016 SHALL, on accept with divisor = 0, go directly to DONE with quotient = all ones, remainder = dividend (unmodified), div_zero = 1, ovf = 0.
REQ-017 SHALL otherwise enter CALC and run exactly n restoring iterations, one per clock, MSB of dividend magnitude first.
REQ-018 SHALL, per iteration: partial remainder (n+1 bits) shifted left with next dividend bit; subtract divisor magnitude using one addsub instance of width n+1 (sub = 1, cin = 0); if cout = 1 (no borrow) keep difference and shift in quotient bit 1, else keep shifted value and shift in 0.
REQ-019 SHALL use a single addsub instance; no other adder or subtractor in the datapath except the two's-complement negations for sign handling.
REQ-020 SHALL, on leaving CALC, apply sign correction (negate quotient/remainder per REQ-015) and enter DONE.
REQ-021 SHALL set ovf = 1 only when signed_op = 1, dividend = 2^(n-1) pattern and divisor = all ones; quotient then = 2^(n-1) pattern, remainder = 0.
REQ-022 SHALL, for a non-zero divisor, raise out_valid exactly n+1 rising edges after the accepting edge; for a zero divisor, 1 edge after.
REQ-023 SHALL assert out_valid only in DONE; quotient, remainder, div_zero and ovf SHALL stay stable while out_valid = 1.
REQ-024 SHALL leave DONE for IDLE on the edge where out_valid & out_ready; no new request is accepted in that same cycle (in_ready = 0 in DONE).
REQ-025 SHALL ignore in_valid, dividend, divisor and signed_op outside IDLE.
REQ-026 SHALL satisfy, for non-zero divisor and no ovf: dividend = quotient*divisor + remainder, |remainder| < |divisor|, in the selected signedness.

Reset
REQ-027 SHALL, on any rising edge with rst_n = 0, enter IDLE and drive out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, ovf = 0, in_ready = 1 from the following cycle.
REQ-028 SHALL abort any in-progress CALC or pending DONE result on reset; the aborted result is never presented.
REQ-029 SHALL treat rst_n as synchronous: a reset pulse between edges has no effect.

Verification (n = 8)
REQ-030 SHALL cover: unsigned 100 / 7 -> quotient 14, remainder 2, flags 0, out_valid 9 edges after accept.
REQ-031 SHALL cover: signed 0xF9 (-7) / 0x02 -> quotient 0xFD (-3), remainder 0xFF (-1); and unsigned 0xF9 / 0x02 -> quotient 0x7C, remainder 0x01.
REQ-032 SHALL cover: 5 / 0 (either mode) -> quotient 0xFF, remainder 0x05, div_zero 1, out_valid 1 edge after accept.
REQ-033 SHALL cover: signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00, ovf 1.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> outputs unchanged, in_ready 0, in_valid toggling ignored; result consumed on first out_ready = 1, in_ready = 1 next cycle.
REQ-035 SHALL cover: rst_n = 0 for one edge at iteration 4 of a CALC -> next cycle IDLE, all outputs 0, in_ready 1; a new 100 / 7 then completes normally.
